// File: rtl/s1423_pkg.sv
// Shared constants and pipeline stage records for the s1423 compare/count chain.
package s1423_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int CNT_W_DEF = 10;
  localparam int SAT_DEF   = 1;

  // Stage payloads are stored at the widest legal operand width; narrower
  // configurations zero-extend, which leaves the unsigned compare unchanged.
  localparam int MAX_W = 32;

  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] cmp_ref;
    logic             en;
  } stage1_t;

  typedef struct packed {
    logic valid;
    logic gt;
    logic eq;
    logic en;
  } stage2_t;

endpackage

// File: rtl/s1423_cmp_chain.sv
// Combinational MSB-first ripple magnitude compare of m against cmp_ref (unsigned).
module s1423_cmp_chain #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] cmp_ref,
  output logic             gt,
  output logic             eq
);

  // NOTE: blocking assignments in always_comb, each output given a default
  // first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (eq && (m[i] != cmp_ref[i])) begin
        gt = m[i];
        eq = 1'b0;
      end
    end
  end

endmodule

// File: rtl/s1423_seq_chain.sv
// Two-stage select/compare pipeline with valid/ready handshake and a
// saturating-or-wrapping event counter of "greater than" results.
module s1423_seq_chain
  import s1423_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SAT   = SAT_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cmp_ref,
  input  logic             en,
  input  logic             cnt_load,
  input  logic [CNT_W-1:0] cnt_din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_eq,
  output logic [CNT_W-1:0] cnt_q,
  output logic             tc
);

  stage1_t s1;
  stage2_t s2;
  logic    advance;
  logic    out_fire;
  logic    cnt_inc;
  logic    cmp_gt;
  logic    cmp_eq;

  // Both stages move in lockstep whenever the output stage can drain.
  assign in_ready  = !s2.valid | out_ready;
  assign advance   = in_ready;
  assign out_fire  = s2.valid & out_ready;
  assign out_valid = s2.valid;
  assign out_gt    = s2.gt;
  assign out_eq    = s2.eq;
  assign cnt_inc   = out_fire & s2.en & s2.gt;
  assign tc        = &cnt_q;

  s1423_cmp_chain #(
    .WIDTH (MAX_W)
  ) u_cmp (
    .m       (s1.m),
    .cmp_ref (s1.cmp_ref),
    .gt      (cmp_gt),
    .eq      (cmp_eq)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage order inside the block does not matter.
  always_ff @(posedge CK) begin
    if (RST) begin
      s1.valid <= 1'b0;
      s2       <= '0;
    end else if (advance) begin
      s1.valid <= in_valid;
      s2.valid <= s1.valid;
      s2.gt    <= s1.valid & cmp_gt;
      s2.eq    <= s1.valid & cmp_eq;
      s2.en    <= s1.en;
    end
  end

  // NOTE: the stage-1 payload is deliberately not reset; it is only ever
  // observed qualified by s1.valid, so a reset would just cost enable logic.
  always_ff @(posedge CK) begin
    if (advance && in_valid) begin
      s1.m       <= MAX_W'(sel ? b : a);
      s1.cmp_ref <= MAX_W'(cmp_ref);
      s1.en      <= en;
    end
  end

  // A load wins over a same-cycle increment, which is then lost.
  always_ff @(posedge CK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= cnt_din;
    end else if (cnt_inc) begin
      if (!((SAT != 0) && tc)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_s1423_seq_chain.sv
// Directed self-checking bench for s1423_seq_chain; a saturating and a
// wrapping instance share all inputs.
module tb_s1423_seq_chain;

  localparam int W  = 5;
  localparam int CW = 4;

  logic          CK;
  logic          RST;
  logic          in_valid;
  logic          sel;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  cmp_ref;
  logic          en;
  logic          cnt_load;
  logic [CW-1:0] cnt_din;
  logic          out_ready;

  logic          in_ready,  in_ready_w;
  logic          out_valid, out_valid_w;
  logic          out_gt,    out_gt_w;
  logic          out_eq,    out_eq_w;
  logic [CW-1:0] cnt_q,     cnt_q_w;
  logic          tc,        tc_w;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt;
  int exp_cnt_w;

  s1423_seq_chain #(.WIDTH(W), .CNT_W(CW), .SAT(1)) dut (
    .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .a(a), .b(b), .cmp_ref(cmp_ref), .en(en), .cnt_load(cnt_load),
    .cnt_din(cnt_din), .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .cnt_q(cnt_q), .tc(tc)
  );

  s1423_seq_chain #(.WIDTH(W), .CNT_W(CW), .SAT(0)) dut_w (
    .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_w), .sel(sel),
    .a(a), .b(b), .cmp_ref(cmp_ref), .en(en), .cnt_load(cnt_load),
    .cnt_din(cnt_din), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_gt(out_gt_w), .out_eq(out_eq_w), .cnt_q(cnt_q_w), .tc(tc_w)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input int av, input int bv,
                       input int rv, input logic e);
    in_valid = v;
    sel      = s;
    a        = W'(av);
    b        = W'(bv);
    cmp_ref  = W'(rv);
    en       = e;
  endtask

  task automatic test_reset();
    RST = 1'b1; out_ready = 1'b1; cnt_load = 1'b0; cnt_din = '0;
    drive(1'b1, 1'b0, 20, 3, 10, 1'b1);
    repeat (3) step();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_gt, out_eq, tc} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_gt, out_eq, tc});
    end
    n_cmp++;
    if (cnt_q !== 4'd0 || cnt_q_w !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_q, cnt_q_w);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    exp_cnt = 0; exp_cnt_w = 0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 20, 3, 10, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency1: got out_valid=%b expected 0", out_valid);
    end
    step();
    n_cmp++;
    if ({out_valid, out_gt, out_eq} !== 3'b110 || cnt_q !== 4'd0) begin
      n_bad++; $display("FAIL basic_result: got v/gt/eq=%b cnt=%0d expected 110 cnt=0",
                        {out_valid, out_gt, out_eq}, cnt_q);
    end
    step();
    exp_cnt = 1; exp_cnt_w = 1;
    n_cmp++;
    if (cnt_q !== CW'(exp_cnt) || cnt_q_w !== CW'(exp_cnt_w) || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_count: got cnt=%0d/%0d v=%b expected 1/1 v=0",
                        cnt_q, cnt_q_w, out_valid);
    end
  endtask

  task automatic test_compare();
    // sel, a, b, ref, en, expected gt, expected eq
    int vec[5][7] = '{'{1, 31, 10, 10, 1, 0, 1},
                      '{0,  3, 20, 10, 1, 0, 0},
                      '{0, 11,  0, 10, 0, 1, 0},
                      '{1,  0, 31, 30, 1, 1, 0},
                      '{0,  0,  0,  0, 1, 0, 1}};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vec[i][0][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4][0]);
      step();
      drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
      step();
      n_cmp++;
      if ({out_valid, out_gt, out_eq} !== {1'b1, vec[i][5][0], vec[i][6][0]}) begin
        n_bad++; $display("FAIL cmp_vec%0d: got v/gt/eq=%b expected 1%0d%0d", i,
                          {out_valid, out_gt, out_eq}, vec[i][5], vec[i][6]);
      end
      step();
      if (vec[i][4] == 1 && vec[i][5] == 1) begin
        exp_cnt++; exp_cnt_w++;
      end
      n_cmp++;
      if (cnt_q !== CW'(exp_cnt) || cnt_q_w !== CW'(exp_cnt_w)) begin
        n_bad++; $display("FAIL cmp_cnt%0d: got %0d/%0d expected %0d/%0d", i,
                          cnt_q, cnt_q_w, exp_cnt, exp_cnt_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    int av[4]  = '{17, 16, 15, 31};
    logic [1:0] ge[4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 1'b0, av[i], 0, 16, 1'b1);
      else       drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready);
      end
      step();
      if (i >= 1) begin
        n_cmp++;
        if ({out_valid, out_gt, out_eq} !== {1'b1, ge[i-1]}) begin
          n_bad++; $display("FAIL b2b_out%0d: got v/gt/eq=%b expected 1%b", i - 1,
                            {out_valid, out_gt, out_eq}, ge[i-1]);
        end
      end
    end
    step();
    exp_cnt += 2; exp_cnt_w += 2;
    n_cmp++;
    if (out_valid !== 1'b0 || cnt_q !== CW'(exp_cnt) || cnt_q_w !== CW'(exp_cnt_w)) begin
      n_bad++; $display("FAIL b2b_end: got v=%b cnt=%0d/%0d expected v=0 cnt=%0d/%0d",
                        out_valid, cnt_q, cnt_q_w, exp_cnt, exp_cnt_w);
    end
  endtask

  task automatic test_saturate();
    cnt_load = 1'b1; cnt_din = 4'd15;
    step();
    cnt_load = 1'b0;
    n_cmp++;
    if ({cnt_q, tc} !== {4'd15, 1'b1} || {cnt_q_w, tc_w} !== {4'd15, 1'b1}) begin
      n_bad++; $display("FAIL sat_load: got cnt/tc=%0d,%b / %0d,%b expected 15,1 / 15,1",
                        cnt_q, tc, cnt_q_w, tc_w);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 20, 0, 1, 1'b1);
      else       drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
      step();
      if (i == 2) begin
        n_cmp++;
        if ({cnt_q, tc} !== {4'd15, 1'b1} || {cnt_q_w, tc_w} !== {4'd0, 1'b0}) begin
          n_bad++; $display("FAIL sat_first: got %0d,%b / %0d,%b expected 15,1 / 0,0",
                            cnt_q, tc, cnt_q_w, tc_w);
        end
      end
    end
    exp_cnt = 15; exp_cnt_w = 2;
    n_cmp++;
    if ({cnt_q, tc} !== {4'd15, 1'b1} || cnt_q_w !== CW'(exp_cnt_w)) begin
      n_bad++; $display("FAIL sat_end: got %0d,%b / %0d expected 15,1 / %0d",
                        cnt_q, tc, cnt_q_w, exp_cnt_w);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b0, 20, 0, 1, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    step();
    n_cmp++;
    if ({out_valid, out_gt} !== 2'b11) begin
      n_bad++; $display("FAIL load_pre: got v/gt=%b expected 11", {out_valid, out_gt});
    end
    cnt_load = 1'b1; cnt_din = 4'd7;
    step();
    cnt_load = 1'b0;
    exp_cnt = 7; exp_cnt_w = 7;
    n_cmp++;
    if (cnt_q !== 4'd7 || cnt_q_w !== 4'd7) begin
      n_bad++; $display("FAIL load_prio: got %0d/%0d expected 7/7", cnt_q, cnt_q_w);
    end
    step();
    n_cmp++;
    if (cnt_q !== 4'd7 || cnt_q_w !== 4'd7) begin
      n_bad++; $display("FAIL load_hold: got %0d/%0d expected 7/7", cnt_q, cnt_q_w);
    end
  endtask

  task automatic test_backpressure();
    // per cycle: out_ready, in_valid, a, ref, expected in_ready, expected v/gt/eq
    int sc[8][6] = '{'{0, 1, 20, 10, 1, 3'b000},
                     '{0, 1, 10, 10, 1, 3'b000},
                     '{0, 1, 31,  0, 0, 3'b110},
                     '{0, 1, 31,  0, 0, 3'b110},
                     '{1, 1, 31,  0, 1, 3'b110},
                     '{1, 0,  0,  0, 1, 3'b101},
                     '{1, 0,  0,  0, 1, 3'b110},
                     '{1, 0,  0,  0, 1, 3'b000}};
    for (int i = 0; i < 8; i++) begin
      out_ready = sc[i][0][0];
      drive(sc[i][1][0], 1'b0, sc[i][2], 0, sc[i][3], 1'b1);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, out_gt, out_eq} !== {sc[i][4][0], sc[i][5][2:0]}) begin
        n_bad++; $display("FAIL bp_cyc%0d: got rdy/v/gt/eq=%b expected %0d%b", i,
                          {in_ready, out_valid, out_gt, out_eq}, sc[i][4], sc[i][5][2:0]);
      end
      if (i == 3) begin
        n_cmp++;
        if (cnt_q !== CW'(exp_cnt)) begin
          n_bad++; $display("FAIL bp_stall_cnt: got %0d expected %0d", cnt_q, exp_cnt);
        end
      end
      step();
    end
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    exp_cnt += 2; exp_cnt_w += 2;
    n_cmp++;
    if (cnt_q !== CW'(exp_cnt) || cnt_q_w !== CW'(exp_cnt_w) || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_end: got cnt=%0d/%0d v=%b expected %0d/%0d v=0",
                        cnt_q, cnt_q_w, out_valid, exp_cnt, exp_cnt_w);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 20, 0, 1, 1'b1);
    step();
    step();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    RST = 1'b1;
    step();
    n_cmp++;
    if ({out_valid, tc} !== 2'b00 || cnt_q !== 4'd0 || cnt_q_w !== 4'd0) begin
      n_bad++; $display("FAIL rst_flight: got v/tc=%b cnt=%0d/%0d expected 00 cnt=0/0",
                        {out_valid, tc}, cnt_q, cnt_q_w);
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready: got %b expected 1", in_ready);
    end
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || cnt_q !== 4'd0 || cnt_q_w !== 4'd0) begin
      n_bad++; $display("FAIL rst_no_late: got v=%b cnt=%0d/%0d expected v=0 cnt=0/0",
                        out_valid, cnt_q, cnt_q_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compare();
    test_back_to_back();
    test_saturate();
    test_load_priority();
    test_backpressure();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/s1423_seq_chain.md
S1423_SEQ_CHAIN -- requirements
Module: s1423_seq_chain

Interface
REQ-001 Parameter WIDTH, default 5: operand and reference width in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 10: event counter width in bits, legal range 2..32.
REQ-003 Parameter SAT, default 1: 1 means the counter saturates at maximum; 0 means it wraps to 0.
REQ-004 CK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  sample present on sel/a/b/ref/en.
REQ-007 in_ready  output  1  block accepts sample this cycle.
REQ-008 sel  input  1  source select: 0 selects a, 1 selects b.
REQ-009 a, b  input  WIDTH  candidate operands.
REQ-010 ref  input  WIDTH  comparison threshold.
REQ-011 en  input  1  count enable, carried with the sample.
REQ-012 cnt_load  input  1  load counter from cnt_din.
REQ-013 cnt_din  input  CNT_W  counter load value.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_gt  output  1  selected operand > ref, unsigned.
REQ-017 out_eq  output  1  selected operand == ref.
REQ-018 cnt_q  output  CNT_W  registered counter value.
REQ-019 tc  output  1  cnt_q equals all-ones.

Function
REQ-020 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-021 Stage 1 SHALL register the mux result m = sel ? b : a, together with ref and en, on input fire.
REQ-022 Stage 2 SHALL register gt/eq, computed as an MSB-first ripple compare of m against ref, together with en.
REQ-023 Latency from input fire to out_valid SHALL be exactly 2 cycles when out_ready is held high.
REQ-024 Throughput SHALL be one sample per cycle when out_ready is held high.
REQ-025 in_ready = !s2_valid | out_ready; the whole pipeline advances together, and s2 receives s1 only when s2 is empty or firing.
REQ-026 out_valid, out_gt and out_eq SHALL hold stable while out_valid & !out_ready.
REQ-027 On output fire with en=1 and out_gt=1, the counter SHALL increment by 1.
REQ-028 On output fire with en=0, or with out_gt=0, the counter SHALL hold.
REQ-029 Counter at all-ones with an increment: SAT=1 holds at all-ones; SAT=0 wraps to 0.
REQ-030 cnt_load=1 SHALL load cnt_din next cycle; load has priority over a simultaneous increment, and that increment is dropped.
REQ-031 cnt_load SHALL act regardless of pipeline state and SHALL NOT stall the pipeline.
REQ-032 tc SHALL be combinational from cnt_q only.
REQ-033 out_eq=1 implies out_gt=0.

Reset
REQ-034 RST=1 at a rising edge SHALL clear s1_valid, s2_valid, out_gt, out_eq and cnt_q to 0; tc therefore reads 0.
REQ-035 RST SHALL take priority over cnt_load and over any fire; in-flight samples are discarded without counting.
REQ-036 in_ready SHALL read 1 in the first cycle after reset is released.

Structure
REQ-037 Package s1423_pkg SHALL hold the WIDTH/CNT_W/SAT default constants and the stage-record typedef (valid, m, ref, en).
REQ-038 Sub-module s1423_cmp_chain SHALL implement the combinational WIDTH-parametrised ripple compare (gt, eq).
REQ-039 The top level contains the two pipeline stages, the handshake and the counter only.

Verification (WIDTH=5, CNT_W=4)
REQ-040 Reset, then sel=0, a=20, b=3, ref=10, en=1, out_ready=1 -> out_valid two cycles later, out_gt=1, out_eq=0, cnt_q=1 the next cycle.
REQ-041 sel=1, a=31, b=10, ref=10 -> out_gt=0, out_eq=1, cnt_q unchanged.
REQ-042 SAT=1, cnt_load with cnt_din=15, then 3 gt samples with en=1 -> cnt_q=15, tc=1; with SAT=0 the first sample gives cnt_q=0, tc=0.
REQ-043 out_ready=0 for 4 cycles while 3 samples are offered -> in_ready drops after 2 accepted, outputs held stable, and no sample is lost or duplicated after release.
REQ-044 cnt_load with cnt_din=7 in the same cycle as a counting output fire -> cnt_q=7, not 8.
REQ-045 RST asserted with 2 samples in flight -> out_valid=0 and cnt_q=0 next cycle, and no late count occurs.
